// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the execute stage and the
// RV32M multiply/divide unit. The pipeline side is the master; the unit is
// the slave.
interface muldiv_if #(
    parameter int D_WIDTH = 32
);
    logic               start;
    logic [2:0]         op;
    logic [D_WIDTH-1:0] a;
    logic [D_WIDTH-1:0] b;
    logic               busy;
    logic               done;
    logic [D_WIDTH-1:0] result;

    modport master (
        output start, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Multiply is radix-2 shift-add, divide is restoring division, one bit per
// cycle. Divide-by-zero and signed overflow complete without iterating.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle
// signed 33x33 product instead of the iterative path.
//
// state  | meaning
// IDLE   | waiting for start; operands latched on the start edge
// RUN    | one multiply/divide iteration per cycle, counter 0..D_WIDTH-1
// DONE   | result valid, done pulse, back to IDLE next edge
module muldiv_unit #(
    parameter int D_WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int W = D_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    logic [1:0]     state;
    logic [2:0]     op_q;
    logic           neg_q;      // product / quotient sign
    logic           neg_rem;    // remainder sign (dividend sign)
    logic [5:0]     cnt;
    logic [2*W-1:0] acc;        // {partial product, remaining multiplier bits}
    logic [W-1:0]   opnd;       // |b|: multiplicand or divisor
    logic [W-1:0]   rem;        // partial remainder (never reaches divisor)
    logic [W-1:0]   quo;        // dividend bits shifting out, quotient shifting in
    logic [W-1:0]   result_q;

    logic           a_signed, b_signed, a_neg, b_neg;
    logic [W-1:0]   a_mag, b_mag;
    logic           div_zero, div_ovf;
    logic [W-1:0]   special_res;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] acc_nx;
    logic [W:0]     rem_sh, rem_diff;
    logic [W-1:0]   rem_nx, quo_nx;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix;
    logic [W-1:0]   final_res;

    assign bus.busy   = (state != S_IDLE);
    assign bus.done   = (state == S_DONE);
    assign bus.result = result_q;

    // Operand signedness, magnitudes and bypass cases for the start edge
    always_comb begin
        a_signed    = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                      (bus.op == OP_DIV)  || (bus.op == OP_REM);
        b_signed    = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
        a_neg       = a_signed && bus.a[W-1];
        b_neg       = b_signed && bus.b[W-1];
        a_mag       = a_neg ? -bus.a : bus.a;
        b_mag       = b_neg ? -bus.b : bus.b;
        div_zero    = bus.op[2] && (bus.b == '0);
        div_ovf     = bus.op[2] && !bus.op[0] && (bus.a == MIN_NEG) && (bus.b == '1);
        special_res = '0;
        if (div_zero)
            special_res = bus.op[1] ? bus.a : '1;
        else
            special_res = bus.op[1] ? '0 : MIN_NEG;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [W:0]     fast_a, fast_b;
    logic signed [2*W-1:0] fast_p;
    logic [W-1:0]          fast_res;

    // Single-cycle signed 33x33 product; extension bit carries signedness
    always_comb begin
        fast_a   = {a_signed && bus.a[W-1], bus.a};
        fast_b   = {b_signed && bus.b[W-1], bus.b};
        fast_p   = (2*W)'(fast_a) * (2*W)'(fast_b);
        fast_res = (bus.op == OP_MUL) ? fast_p[W-1:0] : fast_p[2*W-1:W];
    end
`endif

    // One shift-add step and one restoring-division step, plus sign fix-up
    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
        acc_nx   = {mul_sum, acc[W-1:1]};
        rem_sh   = {rem, quo[W-1]};
        rem_diff = rem_sh - {1'b0, opnd};
        rem_nx   = rem_diff[W] ? rem_sh[W-1:0] : rem_diff[W-1:0];
        quo_nx   = {quo[W-2:0], ~rem_diff[W]};
        prod_fix = neg_q ? -acc_nx : acc_nx;
        quo_fix  = neg_q ? -quo_nx : quo_nx;
        rem_fix  = neg_rem ? -rem_nx : rem_nx;
        case (op_q)
            OP_MUL:                        final_res = prod_fix[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_fix[2*W-1:W];
            OP_DIV, OP_DIVU:               final_res = quo_fix;
            default:                       final_res = rem_fix;
        endcase
    end

    // Sequencer: latch on start, iterate, register the result entering DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            neg_rem  <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            rem      <= '0;
            quo      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        neg_q   <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        cnt     <= '0;
                        acc     <= {{W{1'b0}}, a_mag};
                        opnd    <= b_mag;
                        rem     <= '0;
                        quo     <= a_mag;
                        if (div_zero || div_ovf) begin
                            result_q <= special_res;
                            state    <= S_DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!bus.op[2]) begin
                            result_q <= fast_res;
                            state    <= S_DONE;
                        end
`endif
                        else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc <= acc_nx;
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(W-1)) begin
                        result_q <= final_res;
                        state    <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
